// File: rtl/spu_addsub_lanes_if.sv
// Beat bus between a stage driver (master) and an spu_addsub_lanes element (slave).
interface spu_addsub_lanes_if #(
    parameter int LANES        = 1,
    parameter int S_DATA0_BITS = 8,
    parameter int S_DATA1_BITS = 8,
    parameter int M_DATA_BITS  = 8
);
    logic [2*LANES-1:0]            s_op;
    logic [S_DATA0_BITS*LANES-1:0] s_data0;
    logic [S_DATA1_BITS*LANES-1:0] s_data1;
    logic                          s_valid;
    logic                          s_clear_ovf;
    logic [M_DATA_BITS*LANES-1:0]  m_data;
    logic                          m_valid;
    logic [LANES-1:0]              m_ovf;
    logic [LANES-1:0]              m_ovf_sticky;

    modport master (
        output s_op, s_data0, s_data1, s_valid, s_clear_ovf,
        input  m_data, m_valid, m_ovf, m_ovf_sticky
    );

    modport slave (
        input  s_op, s_data0, s_data1, s_valid, s_clear_ovf,
        output m_data, m_valid, m_ovf, m_ovf_sticky
    );
endinterface

// File: rtl/spu_addsub_lanes.sv
// Multi-lane add/sub/accumulate element: per-lane op, wrap or saturate mapping,
// overflow flags and a cke-gated LATENCY-deep result pipeline.
module spu_addsub_lanes #(
    parameter int LATENCY      = 1,
    parameter int LANES        = 1,
    parameter int S_DATA0_BITS = 8,
    parameter int S_DATA1_BITS = 8,
    parameter int M_DATA_BITS  = 8,
    parameter bit SIGNED       = 1'b1,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    spu_addsub_lanes_if.slave     bus
);
    localparam int M     = M_DATA_BITS;
    localparam int MAX01 = (S_DATA0_BITS > S_DATA1_BITS) ? S_DATA0_BITS : S_DATA1_BITS;
    localparam int W     = ((MAX01 > M) ? MAX01 : M) + 2;
    localparam int D     = (LATENCY < 1) ? 1 : LATENCY;

    localparam logic signed [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
    localparam logic signed [W-1:0] HI_W  = SIGNED ? ((ONE_W <<< (M-1)) - ONE_W)
                                                   : ((ONE_W <<< M) - ONE_W);
    localparam logic signed [W-1:0] LO_W  = SIGNED ? -(ONE_W <<< (M-1)) : {W{1'b0}};

    if (LATENCY < 1) begin : g_bad_latency
        $error("spu_addsub_lanes: LATENCY must be >= 1");
    end

    function automatic logic signed [W-1:0] ext_a(input logic [S_DATA0_BITS-1:0] v);
        return {{(W-S_DATA0_BITS){SIGNED & v[S_DATA0_BITS-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] ext_b(input logic [S_DATA1_BITS-1:0] v);
        return {{(W-S_DATA1_BITS){SIGNED & v[S_DATA1_BITS-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] ext_m(input logic [M-1:0] v);
        return {{(W-M){SIGNED & v[M-1]}}, v};
    endfunction

    // Returns {ovf, mapped result}; the exact value always fits W bits
    function automatic logic [M:0] map_result(input logic signed [W-1:0] x);
        logic         ovf_v;
        logic [M-1:0] d_v;
        ovf_v = (x > HI_W) || (x < LO_W);
        if (SATURATE && (x > HI_W)) begin
            d_v = HI_W[M-1:0];
        end else if (SATURATE && (x < LO_W)) begin
            d_v = LO_W[M-1:0];
        end else begin
            d_v = x[M-1:0];
        end
        return {ovf_v, d_v};
    endfunction

    logic [M-1:0]         acc_r        [LANES];
    logic [M-1:0]         result_s     [LANES];
    logic [LANES-1:0]     ovf_s;
    logic [LANES-1:0]     acc_we_s;
    logic [M*LANES-1:0]   stage_in_s;
    logic [M*LANES-1:0]   data_pipe_r  [D];
    logic [LANES-1:0]     ovf_pipe_r   [D];
    logic [D-1:0]         valid_pipe_r;
    logic [LANES-1:0]     sticky_r;
    logic                 last_valid_s;
    logic [LANES-1:0]     last_ovf_s;

    // Per-lane operand selection, exact arithmetic and range mapping
    always_comb begin
        logic signed [W-1:0] a_v;
        logic signed [W-1:0] b_v;
        logic signed [W-1:0] c_v;
        logic signed [W-1:0] exact_v;
        logic [M:0]          map_v;
        a_v        = '0;
        b_v        = '0;
        c_v        = '0;
        exact_v    = '0;
        map_v      = '0;
        result_s   = '{default: '0};
        ovf_s      = '0;
        acc_we_s   = '0;
        stage_in_s = '0;
        for (int i = 0; i < LANES; i++) begin
            a_v = ext_a(bus.s_data0[i*S_DATA0_BITS +: S_DATA0_BITS]);
            b_v = ext_b(bus.s_data1[i*S_DATA1_BITS +: S_DATA1_BITS]);
            c_v = ext_m(acc_r[i]);
            case (bus.s_op[2*i +: 2])
                2'b00:   exact_v = a_v + b_v;
                2'b01:   exact_v = a_v - b_v;
                2'b10:   exact_v = c_v + a_v;
                2'b11:   exact_v = a_v;
                default: exact_v = a_v;
            endcase
            map_v                = map_result(exact_v);
            result_s[i]          = map_v[M-1:0];
            ovf_s[i]             = map_v[M] & bus.s_valid;
            acc_we_s[i]          = bus.s_valid & bus.s_op[2*i+1];
            stage_in_s[i*M +: M] = map_v[M-1:0];
        end
    end

    // Beat about to be loaded into the output stage, which feeds the sticky flags
    always_comb begin
        last_valid_s = bus.s_valid;
        last_ovf_s   = ovf_s;
        for (int k = 1; k < D; k++) begin
            last_valid_s = valid_pipe_r[k-1];
            last_ovf_s   = ovf_pipe_r[k-1];
        end
    end

    // Pipeline stages, accumulators and sticky flags; reset overrides cke
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < D; k++) begin
                data_pipe_r[k] <= '0;
                ovf_pipe_r[k]  <= '0;
            end
            for (int i = 0; i < LANES; i++) begin
                acc_r[i] <= '0;
            end
            valid_pipe_r <= '0;
            sticky_r     <= '0;
        end else if (cke) begin
            data_pipe_r[0]  <= stage_in_s;
            ovf_pipe_r[0]   <= ovf_s;
            valid_pipe_r[0] <= bus.s_valid;
            for (int k = 1; k < D; k++) begin
                data_pipe_r[k]  <= data_pipe_r[k-1];
                ovf_pipe_r[k]   <= ovf_pipe_r[k-1];
                valid_pipe_r[k] <= valid_pipe_r[k-1];
            end
            for (int i = 0; i < LANES; i++) begin
                if (acc_we_s[i]) begin
                    acc_r[i] <= result_s[i];
                end
            end
            // A new overflow landing with a clear still leaves the flag set
            sticky_r <= (sticky_r & ~{LANES{bus.s_clear_ovf}})
                      | ({LANES{last_valid_s}} & last_ovf_s);
        end
    end

    assign bus.m_data       = data_pipe_r[D-1];
    assign bus.m_valid      = valid_pipe_r[D-1];
    assign bus.m_ovf        = ovf_pipe_r[D-1];
    assign bus.m_ovf_sticky = sticky_r;
endmodule

// File: tb/tb_spu_addsub_lanes.sv
// Bench: 2-lane LATENCY=3 signed-wrap DUT checked through a scoreboard, plus three
// single-lane LATENCY=1 DUTs covering signed/unsigned saturate and unsigned wrap.
module tb_spu_addsub_lanes;
    localparam int MAIN_LAT = 3;

    logic clk;
    logic reset;
    logic cke_m;
    logic cke_s;
    int   errors;
    int   checks;

    spu_addsub_lanes_if #(.LANES(2), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .M_DATA_BITS(8)) bus_m ();
    spu_addsub_lanes_if #(.LANES(1), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .M_DATA_BITS(8)) bus_b ();
    spu_addsub_lanes_if #(.LANES(1), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .M_DATA_BITS(8)) bus_c ();
    spu_addsub_lanes_if #(.LANES(1), .S_DATA0_BITS(8), .S_DATA1_BITS(8), .M_DATA_BITS(8)) bus_d ();

    spu_addsub_lanes #(.LATENCY(MAIN_LAT), .LANES(2), .S_DATA0_BITS(8), .S_DATA1_BITS(8),
                       .M_DATA_BITS(8), .SIGNED(1'b1), .SATURATE(1'b0))
        dut_m (.clk(clk), .reset(reset), .cke(cke_m), .bus(bus_m));
    spu_addsub_lanes #(.LATENCY(1), .LANES(1), .S_DATA0_BITS(8), .S_DATA1_BITS(8),
                       .M_DATA_BITS(8), .SIGNED(1'b1), .SATURATE(1'b1))
        dut_b (.clk(clk), .reset(reset), .cke(cke_s), .bus(bus_b));
    spu_addsub_lanes #(.LATENCY(1), .LANES(1), .S_DATA0_BITS(8), .S_DATA1_BITS(8),
                       .M_DATA_BITS(8), .SIGNED(1'b0), .SATURATE(1'b1))
        dut_c (.clk(clk), .reset(reset), .cke(cke_s), .bus(bus_c));
    spu_addsub_lanes #(.LATENCY(1), .LANES(1), .S_DATA0_BITS(8), .S_DATA1_BITS(8),
                       .M_DATA_BITS(8), .SIGNED(1'b0), .SATURATE(1'b0))
        dut_d (.clk(clk), .reset(reset), .cke(cke_s), .bus(bus_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
        logic [1:0]  ovf;
    } exp_t;

    exp_t exp_q[$];
    int   acc_m [2];
    int   en_count;

    // Reference for the signed-wrap main DUT, in plain integer arithmetic
    task automatic model_lane(input int lane, input logic [1:0] op, input logic [7:0] a,
                              input logic [7:0] b, output logic [7:0] r, output logic o,
                              output int acc_new);
        int ai;
        int bi;
        int x;
        ai = int'($signed(a));
        bi = int'($signed(b));
        case (op)
            2'b00:   x = ai + bi;
            2'b01:   x = ai - bi;
            2'b10:   x = acc_m[lane] + ai;
            default: x = ai;
        endcase
        o       = (x > 127) || (x < -128);
        r       = x[7:0];
        acc_new = op[1] ? int'($signed(r)) : acc_m[lane];
    endtask

    // Drive one cycle on the main DUT, push the accepted beat, pop what comes out
    task automatic beat(input logic [1:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [1:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic v, input logic ck, input logic clr);
        logic [7:0] r0;
        logic [7:0] r1;
        logic       o0;
        logic       o1;
        int         n0;
        int         n1;
        exp_t       e;
        exp_t       g;
        model_lane(0, op0, a0, b0, r0, o0, n0);
        model_lane(1, op1, a1, b1, r1, o1, n1);
        bus_m.s_op        = {op1, op0};
        bus_m.s_data0     = {a1, a0};
        bus_m.s_data1     = {b1, b0};
        bus_m.s_valid     = v;
        bus_m.s_clear_ovf = clr;
        cke_m             = ck;
        @(posedge clk);
        if (ck) begin
            en_count++;
            if (v) begin
                acc_m[0] = n0;
                acc_m[1] = n1;
                e.due    = en_count + MAIN_LAT - 1;
                e.data   = {r1, r0};
                e.ovf    = {o1, o0};
                exp_q.push_back(e);
            end
        end
        #1;
        if (ck) begin
            if (bus_m.m_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got valid beat data=%h, required none", bus_m.m_data);
                end else begin
                    g = exp_q.pop_front();
                    checks++;
                    if (bus_m.m_data !== g.data) begin
                        errors++;
                        $display("FAIL sb_data: got %h required %h", bus_m.m_data, g.data);
                    end
                    checks++;
                    if (bus_m.m_ovf !== g.ovf) begin
                        errors++;
                        $display("FAIL sb_ovf: got %b required %b", bus_m.m_ovf, g.ovf);
                    end
                    checks++;
                    if (en_count !== g.due) begin
                        errors++;
                        $display("FAIL sb_latency: arrived at edge %0d required %0d", en_count, g.due);
                    end
                end
            end else begin
                checks++;
                if (bus_m.m_ovf !== 2'b00) begin
                    errors++;
                    $display("FAIL bubble_ovf: got %b required 00", bus_m.m_ovf);
                end
            end
        end
    endtask

    task automatic idle(input logic ck, input logic clr);
        beat(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 1'b0, ck, clr);
    endtask

    // Same stimulus to the three single-lane DUTs for one enabled cycle
    task automatic small_step(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic v);
        bus_b.s_op = op; bus_b.s_data0 = a; bus_b.s_data1 = b; bus_b.s_valid = v;
        bus_c.s_op = op; bus_c.s_data0 = a; bus_c.s_data1 = b; bus_c.s_valid = v;
        bus_d.s_op = op; bus_d.s_data0 = a; bus_d.s_data1 = b; bus_d.s_valid = v;
        cke_s = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cke_m = 1'b0;
        cke_s = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus_m.m_valid, bus_m.m_data, bus_m.m_ovf, bus_m.m_ovf_sticky} !== 21'h0) begin
            errors++;
            $display("FAIL reset_main: got v=%b d=%h o=%b s=%b required all 0",
                     bus_m.m_valid, bus_m.m_data, bus_m.m_ovf, bus_m.m_ovf_sticky);
        end
        checks++;
        if ({bus_b.m_valid, bus_b.m_data, bus_c.m_valid, bus_c.m_data,
             bus_d.m_valid, bus_d.m_data} !== 27'h0) begin
            errors++;
            $display("FAIL reset_small: got b=%h c=%h d=%h required 0",
                     bus_b.m_data, bus_c.m_data, bus_d.m_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_wrap_overflow();
        beat(2'b00, 8'd100, 8'd100, 2'b00, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        checks++;
        if (bus_m.m_data[7:0] !== 8'hC8 || bus_m.m_ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_add: got %h ovf=%b required c8 ovf=1", bus_m.m_data[7:0], bus_m.m_ovf[0]);
        end
        checks++;
        if (bus_m.m_ovf_sticky !== 2'b01) begin
            errors++;
            $display("FAIL wrap_sticky: got %b required 01", bus_m.m_ovf_sticky);
        end
    endtask

    task automatic test_cke_toggle();
        for (int i = 0; i < 8; i++) begin
            beat(2'b10, 8'(20 + 10 * i), 8'h00, 2'b01, 8'(i * 40), 8'd100,
                 (i != 4), (i % 2 == 0), 1'b0);
        end
        for (int i = 0; i < MAIN_LAT; i++) idle(1'b1, 1'b0);
    endtask

    task automatic test_sticky_clear();
        idle(1'b1, 1'b1);
        checks++;
        if (bus_m.m_ovf_sticky !== 2'b00) begin
            errors++;
            $display("FAIL sticky_clear: got %b required 00", bus_m.m_ovf_sticky);
        end
        beat(2'b00, 8'd100, 8'd100, 2'b00, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        checks++;
        if (bus_m.m_ovf_sticky !== 2'b01) begin
            errors++;
            $display("FAIL sticky_clear_vs_ovf: got %b required 01", bus_m.m_ovf_sticky);
        end
        idle(1'b0, 1'b1);
        checks++;
        if (bus_m.m_ovf_sticky !== 2'b01) begin
            errors++;
            $display("FAIL sticky_hold_cke0: got %b required 01", bus_m.m_ovf_sticky);
        end
        idle(1'b1, 1'b1);
        checks++;
        if (bus_m.m_ovf_sticky !== 2'b00) begin
            errors++;
            $display("FAIL sticky_clear2: got %b required 00", bus_m.m_ovf_sticky);
        end
    endtask

    task automatic test_load_acc();
        beat(2'b11, 8'd10, 8'h00, 2'b00, 8'd1, 8'd2, 1'b1, 1'b1, 1'b0);
        beat(2'b10, 8'd5, 8'h00, 2'b00, 8'd3, 8'd4, 1'b1, 1'b1, 1'b0);
        beat(2'b10, 8'd5, 8'h00, 2'b00, 8'hF9, 8'd9, 1'b1, 1'b1, 1'b0);
        beat(2'b10, 8'd5, 8'h00, 2'b00, 8'd50, 8'd60, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        checks++;
        if (bus_m.m_data !== {8'd110, 8'd25}) begin
            errors++;
            $display("FAIL load_acc: got %h required 6e19", bus_m.m_data);
        end
        idle(1'b1, 1'b0);
    endtask

    task automatic test_reset_midflight();
        beat(2'b00, 8'd1, 8'd1, 2'b00, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0);
        beat(2'b00, 8'd1, 8'd1, 2'b00, 8'd2, 8'd2, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        cke_m = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        acc_m[0] = 0;
        acc_m[1] = 0;
        checks++;
        if ({bus_m.m_valid, bus_m.m_data, bus_m.m_ovf, bus_m.m_ovf_sticky} !== 21'h0) begin
            errors++;
            $display("FAIL reset_midflight: got v=%b d=%h o=%b s=%b required all 0",
                     bus_m.m_valid, bus_m.m_data, bus_m.m_ovf, bus_m.m_ovf_sticky);
        end
        beat(2'b10, 8'd1, 8'h00, 2'b11, 8'd7, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        checks++;
        if (bus_m.m_data !== 16'h0701 || bus_m.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL acc_after_reset: got %h v=%b required 0701 v=1", bus_m.m_data, bus_m.m_valid);
        end
        for (int i = 0; i < MAIN_LAT; i++) idle(1'b1, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_signed_saturate();
        small_step(2'b00, 8'd100, 8'd100, 1'b1);
        checks++;
        if (bus_b.m_data !== 8'd127 || bus_b.m_ovf !== 1'b1 || bus_b.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: got %h ovf=%b required 7f ovf=1", bus_b.m_data, bus_b.m_ovf);
        end
        small_step(2'b01, 8'h9C, 8'd100, 1'b1);
        checks++;
        if (bus_b.m_data !== 8'h80 || bus_b.m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: got %h ovf=%b required 80 ovf=1", bus_b.m_data, bus_b.m_ovf);
        end
        small_step(2'b00, 8'd5, 8'hFD, 1'b1);
        checks++;
        if (bus_b.m_data !== 8'd2 || bus_b.m_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sat_inrange: got %h ovf=%b required 02 ovf=0", bus_b.m_data, bus_b.m_ovf);
        end
        checks++;
        if (bus_b.m_ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: got %b required 1", bus_b.m_ovf_sticky);
        end
    endtask

    task automatic test_unsigned();
        small_step(2'b01, 8'd3, 8'd5, 1'b1);
        checks++;
        if (bus_c.m_data !== 8'd0 || bus_c.m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL usat_sub: got %h ovf=%b required 00 ovf=1", bus_c.m_data, bus_c.m_ovf);
        end
        checks++;
        if (bus_d.m_data !== 8'd254 || bus_d.m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL uwrap_sub: got %h ovf=%b required fe ovf=1", bus_d.m_data, bus_d.m_ovf);
        end
        small_step(2'b00, 8'd200, 8'd100, 1'b1);
        checks++;
        if (bus_c.m_data !== 8'd255 || bus_c.m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL usat_add: got %h ovf=%b required ff ovf=1", bus_c.m_data, bus_c.m_ovf);
        end
        checks++;
        if (bus_d.m_data !== 8'd44 || bus_d.m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL uwrap_add: got %h ovf=%b required 2c ovf=1", bus_d.m_data, bus_d.m_ovf);
        end
        small_step(2'b00, 8'd20, 8'd30, 1'b1);
        checks++;
        if (bus_c.m_data !== 8'd50 || bus_c.m_ovf !== 1'b0 || bus_d.m_data !== 8'd50) begin
            errors++;
            $display("FAIL u_inrange: got c=%h d=%h required 32", bus_c.m_data, bus_d.m_data);
        end
        small_step(2'b00, 8'd200, 8'd100, 1'b0);
        checks++;
        if (bus_c.m_valid !== 1'b0 || bus_c.m_ovf !== 1'b0 || bus_d.m_ovf !== 1'b0) begin
            errors++;
            $display("FAIL u_bubble: got v=%b ovf=%b%b required 0 00",
                     bus_c.m_valid, bus_c.m_ovf, bus_d.m_ovf);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        en_count = 0;
        acc_m[0] = 0;
        acc_m[1] = 0;
        reset    = 1'b0;
        cke_m    = 1'b0;
        cke_s    = 1'b0;
        bus_m.s_op = '0; bus_m.s_data0 = '0; bus_m.s_data1 = '0;
        bus_m.s_valid = 1'b0; bus_m.s_clear_ovf = 1'b0;
        bus_b.s_op = '0; bus_b.s_data0 = '0; bus_b.s_data1 = '0;
        bus_b.s_valid = 1'b0; bus_b.s_clear_ovf = 1'b0;
        bus_c.s_op = '0; bus_c.s_data0 = '0; bus_c.s_data1 = '0;
        bus_c.s_valid = 1'b0; bus_c.s_clear_ovf = 1'b0;
        bus_d.s_op = '0; bus_d.s_data0 = '0; bus_d.s_data1 = '0;
        bus_d.s_valid = 1'b0; bus_d.s_clear_ovf = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap_overflow();
        test_cke_toggle();
        test_sticky_clear();
        test_load_acc();
        test_reset_midflight();
        test_signed_saturate();
        test_unsigned();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end
endmodule
